// File: rtl/mux_table_scanner.sv
// mux_table_scanner: registered 2^SEL_W:1 mux used as a truth-table evaluator.
// Direct mode registers table_i[sel_i] each cycle. Scan mode snapshots the
// table and expected vectors, steps an internal select through every input,
// builds a result vector and compares it against the expected snapshot.
//
// Handshake: start_i is a request qualified by mode_i and accepted only in
// IDLE. busy_o is high from the cycle after acceptance until the done_o
// cycle inclusive. done_o is a single-cycle pulse, and match_o is valid from
// the cycle after done_o. start_i while busy_o is high is dropped, not queued.
module mux_table_scanner #(
  parameter int SEL_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [(1<<SEL_W)-1:0]   table_i,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic                    mode_i,
  input  logic                    start_i,
  input  logic [(1<<SEL_W)-1:0]   expected_i,
  output logic                    y_o,
  output logic [SEL_W-1:0]        sel_o,
  output logic [(1<<SEL_W)-1:0]   result_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    match_o,
  output logic [1:0]              dbg_state_o
);

  localparam int N = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_SEL = {SEL_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_start;
  logic [N-1:0]     r_tab;
  logic [N-1:0]     r_exp;
  logic [SEL_W-1:0] r_cnt;
  logic             r_y;
  logic [SEL_W-1:0] r_sel;
  logic [N-1:0]     r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_match;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; a start only counts in IDLE with scan mode selected.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    case (r_state)
      IDLE: begin
        w_start = start_i & mode_i;
        if (w_start) w_next_state = SCAN;
      end
      SCAN: begin
        if (r_cnt == LAST_SEL) w_next_state = DONE;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: direct mux, scan stepping, result capture and compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tab    <= '0;
      r_exp    <= '0;
      r_cnt    <= '0;
      r_y      <= 1'b0;
      r_sel    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_match  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_tab    <= table_i;
            r_exp    <= expected_i;
            r_cnt    <= '0;
            r_result <= '0;
            r_match  <= 1'b0;
            r_busy   <= 1'b1;
          end else if (!mode_i) begin
            r_y   <= table_i[sel_i];
            r_sel <= sel_i;
          end
        end
        SCAN: begin
          r_y             <= r_tab[r_cnt];
          r_sel           <= r_cnt;
          r_result[r_cnt] <= r_tab[r_cnt];
          // The counter stops on the last step instead of wrapping to 0.
          if (r_cnt == LAST_SEL) r_done <= 1'b1;
          else                   r_cnt  <= r_cnt + 1'b1;
        end
        DONE: begin
          r_match <= (r_result == r_exp);
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign y_o         = r_y;
  assign sel_o       = r_sel;
  assign result_o    = r_result;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign match_o     = r_match;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mux_table_scanner.sv
// Bench for mux_table_scanner: an 8-input instance (SEL_W=3) and a 2-input
// instance (SEL_W=1) share one clock and reset. Expected values come from a
// simple model: y = bit sel of the table, a scan reproduces the table
// snapshot one bit per cycle, done_o is N cycles after the first busy cycle,
// and match is table == expected.
module tb_mux_table_scanner;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: SEL_W = 3
  logic [7:0] a_table, a_exp, a_result;
  logic [2:0] a_sel_i, a_sel_o;
  logic       a_mode, a_start, a_y, a_busy, a_done, a_match;
  logic [1:0] a_state;

  // Instance B: SEL_W = 1
  logic [1:0] b_table, b_exp, b_result;
  logic       b_sel_i, b_sel_o;
  logic       b_mode, b_start, b_y, b_busy, b_done, b_match;
  logic [1:0] b_state;

  int n_cmp = 0;
  int n_err = 0;

  mux_table_scanner #(.SEL_W(3)) dut_a (
    .clk(clk), .rst(rst), .table_i(a_table), .sel_i(a_sel_i), .mode_i(a_mode),
    .start_i(a_start), .expected_i(a_exp), .y_o(a_y), .sel_o(a_sel_o),
    .result_o(a_result), .busy_o(a_busy), .done_o(a_done), .match_o(a_match),
    .dbg_state_o(a_state)
  );

  mux_table_scanner #(.SEL_W(1)) dut_b (
    .clk(clk), .rst(rst), .table_i(b_table), .sel_i(b_sel_i), .mode_i(b_mode),
    .start_i(b_start), .expected_i(b_exp), .y_o(b_y), .sel_o(b_sel_o),
    .result_o(b_result), .busy_o(b_busy), .done_o(b_done), .match_o(b_match),
    .dbg_state_o(b_state)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Full scan on instance A. noise: 0 quiet, 1 random input churn,
  // 2 table forced to FF with start pulses at steps 2 and 5.
  task automatic scan_a(input logic [7:0] tab, input logic [7:0] ex, input int noise);
    int dones;
    dones   = 0;
    a_table = tab;
    a_exp   = ex;
    a_mode  = 1'b1;
    a_sel_i = 3'($urandom_range(0, 7));
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("a_scan_busy_rise", 64'(a_busy), 64'(1));
    check("a_scan_result_clr", 64'(a_result), 64'(0));
    check("a_scan_match_clr", 64'(a_match), 64'(0));
    for (int k = 1; k <= 9; k++) begin
      if (noise == 1) begin
        a_table = 8'($urandom);
        a_exp   = 8'($urandom);
        a_sel_i = 3'($urandom_range(0, 7));
        a_mode  = 1'($urandom_range(0, 1));
        a_start = 1'($urandom_range(0, 1));
      end else if (noise == 2) begin
        a_table = 8'hFF;
        a_start = (k == 3 || k == 6);
      end
      tick();
      dones += int'(a_done);
      if (k <= 8) begin
        check("a_scan_sel", 64'(a_sel_o), 64'(k - 1));
        check("a_scan_y", 64'(a_y), 64'(tab[k - 1]));
        check("a_scan_busy", 64'(a_busy), 64'(1));
      end else begin
        check("a_scan_busy_fall", 64'(a_busy), 64'(0));
        check("a_scan_sel_hold", 64'(a_sel_o), 64'(7));
      end
      check("a_scan_done", 64'(a_done), 64'(k == 8));
    end
    a_start = 1'b0;
    a_mode  = 1'b1;
    check("a_scan_result", 64'(a_result), 64'(tab));
    check("a_scan_match", 64'(a_match), 64'(tab == ex));
    check("a_scan_done_count", 64'(dones), 64'(1));
  endtask

  // Full scan on instance B (two steps, done two cycles after first busy cycle).
  task automatic scan_b(input logic [1:0] tab, input logic [1:0] ex);
    b_table = tab;
    b_exp   = ex;
    b_mode  = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_table = 2'($urandom);
    b_exp   = 2'($urandom);
    check("b_scan_busy_rise", 64'(b_busy), 64'(1));
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k <= 2) begin
        check("b_scan_sel", 64'(b_sel_o), 64'(k - 1));
        check("b_scan_y", 64'(b_y), 64'(tab[k - 1]));
      end
      check("b_scan_done", 64'(b_done), 64'(k == 2));
      check("b_scan_busy", 64'(b_busy), 64'(k <= 2));
    end
    check("b_scan_result", 64'(b_result), 64'(tab));
    check("b_scan_match", 64'(b_match), 64'(tab == ex));
  endtask

  initial begin
    logic [7:0] tab8;
    logic [7:0] ex8;
    logic [7:0] last_tab;
    logic [2:0] s;
    logic       last_match;

    // Reset state
    rst = 1'b1;
    a_table = '0; a_exp = '0; a_sel_i = '0; a_mode = 1'b1; a_start = 1'b0;
    b_table = '0; b_exp = '0; b_sel_i = '0; b_mode = 1'b1; b_start = 1'b0;
    tick();
    tick();
    check("rst_y", 64'(a_y), 64'(0));
    check("rst_sel", 64'(a_sel_o), 64'(0));
    check("rst_result", 64'(a_result), 64'(0));
    check("rst_busy", 64'(a_busy), 64'(0));
    check("rst_done", 64'(a_done), 64'(0));
    check("rst_match", 64'(a_match), 64'(0));
    check("rst_state", 64'(a_state), 64'(0));
    rst = 1'b0;

    // Direct sweep of 8'h96
    a_mode  = 1'b0;
    a_table = 8'h96;
    for (int i = 0; i < 8; i++) begin
      a_sel_i = 3'(i);
      tick();
      check("dir96_y", 64'(a_y), 64'((8'h96 >> i) & 1));
      check("dir96_sel", 64'(a_sel_o), 64'(i));
    end

    // start with mode 0 is ignored
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("dir_start_ignored_busy", 64'(a_busy), 64'(0));
    check("dir_start_ignored_state", 64'(a_state), 64'(0));

    // Random direct mode
    for (int i = 0; i < 12; i++) begin
      tab8    = 8'($urandom);
      s       = 3'($urandom_range(0, 7));
      a_table = tab8;
      a_sel_i = s;
      tick();
      check("dir_rand_y", 64'(a_y), 64'((tab8 >> s) & 8'd1));
      check("dir_rand_sel", 64'(a_sel_o), 64'(s));
    end

    // mode 1 without start holds y/sel
    a_mode  = 1'b1;
    a_table = ~a_table;
    a_sel_i = a_sel_i + 3'd1;
    tick();
    check("hold_y", 64'(a_y), 64'((tab8 >> s) & 8'd1));
    check("hold_sel", 64'(a_sel_o), 64'(s));

    // Directed scans, back to back
    scan_a(8'h96, 8'h96, 0);
    scan_a(8'h71, 8'h96, 0);
    scan_a(8'h71, 8'h96, 2);

    // Random scans with churn on every input during the scan
    for (int i = 0; i < 4; i++) begin
      tab8 = 8'($urandom);
      ex8  = ($urandom_range(0, 1) == 1) ? tab8 : 8'($urandom);
      scan_a(tab8, ex8, 1);
    end
    last_tab   = tab8;
    last_match = (tab8 == ex8);

    // Direct mode after a scan overwrites y/sel only
    a_mode  = 1'b0;
    a_table = 8'hA5;
    a_sel_i = 3'd5;
    tick();
    check("post_dir_y", 64'(a_y), 64'(1));
    check("post_dir_sel", 64'(a_sel_o), 64'(5));
    check("post_dir_result", 64'(a_result), 64'(last_tab));
    check("post_dir_match", 64'(a_match), 64'(last_match));

    // Reset at scan step 4
    a_table = 8'h71;
    a_exp   = 8'h71;
    a_mode  = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_sel", 64'(a_sel_o), 64'(3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_y", 64'(a_y), 64'(0));
    check("midrst_sel", 64'(a_sel_o), 64'(0));
    check("midrst_result", 64'(a_result), 64'(0));
    check("midrst_busy", 64'(a_busy), 64'(0));
    check("midrst_done", 64'(a_done), 64'(0));
    check("midrst_match", 64'(a_match), 64'(0));
    check("midrst_state", 64'(a_state), 64'(0));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("midrst_no_done", 64'(a_done), 64'(0));
    end
    scan_a(8'h96, 8'h96, 0);

    // SEL_W = 1 instance
    scan_b(2'b10, 2'b10);
    for (int i = 0; i < 4; i++) scan_b(2'($urandom), 2'($urandom));
    b_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_table = 2'($urandom);
      b_sel_i = 1'($urandom_range(0, 1));
      tick();
      check("b_dir_y", 64'(b_y), 64'(b_table[b_sel_i]));
      check("b_dir_sel", 64'(b_sel_o), 64'(b_sel_i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
